// File: rtl/flowing_light_pkg.sv
// Shared definitions for the flowing-light controller: run-mode and
// bounce-direction encodings plus the default prescaler divide ratio.
package flowing_light_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned DEFAULT_CLK_DIV = 32'd25_000_000;

endpackage

// File: rtl/flowing_light_ctrl_prescaler.sv
// step_prescaler: free-running divide-by-CLK_DIV counter that flags the
// cycle on which the light pattern should advance. Counting freezes while
// en is low and resumes from the partial count.
// Optional build macro FLOWING_LIGHT_SPEED_SEL_EN adds a speed[1:0] input
// that divides the terminal count by 1/2/4/8 (floored at 1).
module step_prescaler
    import flowing_light_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CNT_W   = 32
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
    input  logic [1:0] speed,
`endif
    output logic       tick
);

    localparam logic [CNT_W-1:0] DIV_VAL = CNT_W'(CLK_DIV);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] tc_s;
    logic             hit_s;

`ifdef FLOWING_LIGHT_SPEED_SEL_EN
    logic [1:0]       speed_r;
    logic [CNT_W-1:0] shifted_s;

    // Sample the speed select every cycle; the new rate takes effect next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_r <= 2'b00;
        end else begin
            speed_r <= speed;
        end
    end

    // Terminal count for the selected rate, never allowed below 1.
    always_comb begin
        shifted_s = DIV_VAL >> speed_r;
        if (shifted_s < CNT_W'(32'd2)) begin
            tc_s = CNT_W'(32'd1);
        end else begin
            tc_s = shifted_s - CNT_W'(32'd1);
        end
    end
`else
    // Fixed terminal count.
    always_comb begin
        tc_s = DIV_VAL - CNT_W'(32'd1);
    end
`endif

    // Greater-or-equal so a rate increase that overtakes cnt still ticks.
    assign hit_s = (cnt_r >= tc_s);
    assign tick  = en & hit_s;

    // Prescaler counter: wraps at the terminal count, holds while paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            if (hit_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(32'd1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/flowing_light_ctrl.sv
// flowing_light_ctrl: N_LED-wide flowing light with rotate-left,
// rotate-right, bounce and fill-bar modes plus run/pause. Exports the
// current position and a one-cycle step strobe aligned with new LED values.
// Optional build macro FLOWING_LIGHT_SPEED_SEL_EN adds a speed[1:0] input.
module flowing_light_ctrl
    import flowing_light_pkg::*;
#(
    parameter int unsigned N_LED   = 4,
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned POS_W   = (N_LED > 1) ? $clog2(N_LED) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
    input  logic [1:0]       speed,
`endif
    output logic [N_LED-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic             step
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] ONE_POS  = POS_W'(32'd1);

    logic             advance_s;
    mode_e            mode_s;
    dir_e             eff_dir_s;
    dir_e             nxt_dir_s;
    logic [POS_W-1:0] nxt_pos_s;

    mode_e            mode_r;
    dir_e             dir_r;
    logic [POS_W-1:0] pos_r;
    logic [N_LED-1:0] led_r;
    logic             step_r;

    // One-hot for the moving-dot modes, thermometer [p:0] for fill.
    function automatic logic [N_LED-1:0] encode_led(input mode_e m, input logic [POS_W-1:0] p);
        logic [N_LED-1:0] v;
        v = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (m == MODE_FILL) begin
                v[i] = (i <= int'(p));
            end else begin
                v[i] = (i == int'(p));
            end
        end
        return v;
    endfunction

    step_prescaler #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        .speed (speed),
`endif
        .tick  (advance_s)
    );

    // Next position/direction for the mode presented at this advance.
    always_comb begin
        mode_s    = mode_e'(mode);
        nxt_pos_s = pos_r;
        nxt_dir_s = dir_r;
        if ((mode_s == MODE_BOUNCE) && (mode_r != MODE_BOUNCE)) begin
            eff_dir_s = (pos_r == LAST_POS) ? DIR_DOWN : DIR_UP;
        end else begin
            eff_dir_s = dir_r;
        end

        if (N_LED == 1) begin
            nxt_pos_s = '0;
        end else begin
            case (mode_s)
                MODE_ROL, MODE_FILL: begin
                    if (pos_r >= LAST_POS) begin
                        nxt_pos_s = '0;
                    end else begin
                        nxt_pos_s = pos_r + ONE_POS;
                    end
                end
                MODE_ROR: begin
                    if ((pos_r == '0) || (pos_r > LAST_POS)) begin
                        nxt_pos_s = LAST_POS;
                    end else begin
                        nxt_pos_s = pos_r - ONE_POS;
                    end
                end
                MODE_BOUNCE: begin
                    if ((eff_dir_s == DIR_UP) && (pos_r < LAST_POS)) begin
                        nxt_pos_s = pos_r + ONE_POS;
                    end else if ((eff_dir_s == DIR_DOWN) && (pos_r != '0) && (pos_r <= LAST_POS)) begin
                        nxt_pos_s = pos_r - ONE_POS;
                    end else if (pos_r == '0) begin
                        nxt_pos_s = ONE_POS;
                    end else begin
                        nxt_pos_s = LAST_POS - ONE_POS;
                    end
                    // Direction flips on the very advance that reaches an end.
                    if (nxt_pos_s == LAST_POS) begin
                        nxt_dir_s = DIR_DOWN;
                    end else if (nxt_pos_s == '0) begin
                        nxt_dir_s = DIR_UP;
                    end else if (nxt_pos_s > pos_r) begin
                        nxt_dir_s = DIR_UP;
                    end else begin
                        nxt_dir_s = DIR_DOWN;
                    end
                end
                default: begin
                    nxt_pos_s = '0;
                end
            endcase
        end
    end

    // Pattern state: updates only on an advance; step marks the new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_ROL;
            dir_r  <= DIR_UP;
            pos_r  <= '0;
            led_r  <= N_LED'(32'd1);
            step_r <= 1'b0;
        end else if (advance_s) begin
            mode_r <= mode_s;
            dir_r  <= nxt_dir_s;
            pos_r  <= nxt_pos_s;
            led_r  <= encode_led(mode_s, nxt_pos_s);
            step_r <= 1'b1;
        end else begin
            step_r <= 1'b0;
        end
    end

    assign led  = led_r;
    assign pos  = pos_r;
    assign step = step_r;

endmodule

// File: tb/tb_flowing_light_ctrl.sv
// Table-driven bench for flowing_light_ctrl (N_LED=4, CLK_DIV=4) with a
// single-LED instance alongside and, when FLOWING_LIGHT_SPEED_SEL_EN is
// defined, a CLK_DIV=16 instance exercising the speed select.
module tb_flowing_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] led;
    logic [1:0] pos;
    logic       step;
    logic [0:0] led1;
    logic [0:0] pos1;
    logic       step1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef FLOWING_LIGHT_SPEED_SEL_EN
    logic [1:0] spd0 = 2'b00;
    logic [1:0] spd;
    logic [3:0] led_s;
    logic [1:0] pos_s;
    logic       step_s;
`endif

    flowing_light_ctrl #(.N_LED(4), .CLK_DIV(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        .speed(spd0),
`endif
        .led(led), .pos(pos), .step(step)
    );

    flowing_light_ctrl #(.N_LED(1), .CLK_DIV(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        .speed(spd0),
`endif
        .led(led1), .pos(pos1), .step(step1)
    );

`ifdef FLOWING_LIGHT_SPEED_SEL_EN
    flowing_light_ctrl #(.N_LED(4), .CLK_DIV(16), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .speed(spd),
        .led(led_s), .pos(pos_s), .step(step_s)
    );
`endif

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic [3:0] led;
        logic [1:0] pos;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] m, input logic [3:0] l, input logic [1:0] p);
        vec_t v;
        v.rst = r; v.mode = m; v.led = l; v.pos = p;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sel_step(input int which);
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        if (which == 1) return step_s;
`endif
        return step;
    endfunction

    // Count negedges until the chosen step strobe is seen (bounded).
    task automatic wait_step(input int which, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sel_step(which) && cyc < 40);
        if (!sel_step(which)) begin
            n_checks++;
            n_fail++;
            $display("FAIL step_timeout: got no step after %0d cycles expected one", cyc);
        end
    endtask

    // Full reset cycle, checks reset values, releases with en=1 and mode m.
    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        check("rst_led", 32'(led), 32'h1);
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        mode  = m;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic hold_ok;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        spd   = 2'b00;
`endif
        // rotate left
        add(1'b1, 2'b00, 4'b0010, 2'd1); add(1'b0, 2'b00, 4'b0100, 2'd2);
        add(1'b0, 2'b00, 4'b1000, 2'd3); add(1'b0, 2'b00, 4'b0001, 2'd0);
        // rotate right
        add(1'b1, 2'b01, 4'b1000, 2'd3); add(1'b0, 2'b01, 4'b0100, 2'd2);
        add(1'b0, 2'b01, 4'b0010, 2'd1); add(1'b0, 2'b01, 4'b0001, 2'd0);
        // bounce
        add(1'b1, 2'b10, 4'b0010, 2'd1); add(1'b0, 2'b10, 4'b0100, 2'd2);
        add(1'b0, 2'b10, 4'b1000, 2'd3); add(1'b0, 2'b10, 4'b0100, 2'd2);
        add(1'b0, 2'b10, 4'b0010, 2'd1); add(1'b0, 2'b10, 4'b0001, 2'd0);
        add(1'b0, 2'b10, 4'b0010, 2'd1); add(1'b0, 2'b10, 4'b0100, 2'd2);
        // fill, then mode changes at advances
        add(1'b1, 2'b11, 4'b0011, 2'd1); add(1'b0, 2'b11, 4'b0111, 2'd2);
        add(1'b0, 2'b11, 4'b1111, 2'd3); add(1'b0, 2'b11, 4'b0001, 2'd0);
        add(1'b0, 2'b11, 4'b0011, 2'd1); add(1'b0, 2'b11, 4'b0111, 2'd2);
        add(1'b0, 2'b00, 4'b1000, 2'd3); add(1'b0, 2'b10, 4'b0100, 2'd2);
        add(1'b0, 2'b01, 4'b0010, 2'd1); add(1'b0, 2'b11, 4'b0111, 2'd2);
        add(1'b0, 2'b10, 4'b1000, 2'd3); add(1'b0, 2'b10, 4'b0100, 2'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset(tbl[i].mode);
            end else begin
                mode = tbl[i].mode;
            end
            wait_step(0, cyc);
            check($sformatf("v%0d_period", i), 32'(cyc), 32'd4);
            check($sformatf("v%0d_led", i), 32'(led), 32'(tbl[i].led));
            check($sformatf("v%0d_pos", i), 32'(pos), 32'(tbl[i].pos));
            check($sformatf("v%0d_led1", i), 32'(led1), 32'h1);
            check($sformatf("v%0d_pos1", i), 32'(pos1), 32'h0);
            check($sformatf("v%0d_step1", i), 32'(step1), 32'h1);
        end

        // Pause at cnt=2 for 10 cycles, then resume: advance 2 cycles later.
        do_reset(2'b00);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        hold_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (step !== 1'b0 || led !== 4'b0001 || pos !== 2'd0) hold_ok = 1'b0;
        end
        check("pause_hold", 32'(hold_ok), 32'h1);
        en = 1'b1;
        wait_step(0, cyc);
        check("resume_period", 32'(cyc), 32'd2);
        check("resume_led", 32'(led), 32'b0010);
        check("resume_pos", 32'(pos), 32'd1);

        // Asynchronous reset between clock edges while step is high.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'h1);
        check("async_pos", 32'(pos), 32'h0);
        check("async_step", 32'(step), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // Partial count must be discarded by reset.
        do_reset(2'b00);
        wait_step(0, cyc);
        check("rst_discard_period", 32'(cyc), 32'd4);
        check("rst_discard_led", 32'(led), 32'b0010);

`ifdef FLOWING_LIGHT_SPEED_SEL_EN
        spd = 2'b10;
        do_reset(2'b00);
        wait_step(1, cyc);
        wait_step(1, cyc);
        check("speed2_period", 32'(cyc), 32'd4);
        spd = 2'b11;
        wait_step(1, cyc);
        wait_step(1, cyc);
        check("speed3_period", 32'(cyc), 32'd2);
        wait_step(1, cyc);
        check("speed3_period2", 32'(cyc), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
